// File: rtl/fp_add_pkg.sv
// Shared types and constants for the FP16 adder arbiter and its response FIFO.
package fp_add_pkg;

    localparam int FP16_W   = 16;
    localparam int FLAG_W   = 2;

    // Bit positions inside the {overflow,underflow} flag pair.
    localparam int OVF      = 1;
    localparam int UNF      = 0;

    // The FIFO entry carries a fixed-width ID field so the type can live here;
    // the top zero-extends its ID_W-bit tag into it (ID_W must not exceed this).
    localparam int RSP_ID_W = 8;

    typedef struct packed {
        logic [RSP_ID_W-1:0] id;
        logic [FP16_W-1:0]   sum;
        logic [FLAG_W-1:0]   flags;
    } rsp_entry_t;

endpackage

// File: rtl/fp_add_rsp_fifo.sv
// Synchronous response FIFO holding {id,sum,flags} entries; DEPTH need not be a power of two.
module fp_add_rsp_fifo
    import fp_add_pkg::*;
#(
    parameter int DEPTH = 9,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  rsp_entry_t       push_data,
    input  logic             pop,
    output rsp_entry_t       head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Write the incoming entry at the tail.
    // NOTE: the storage array is deliberately not reset; only pointers and count are, so stale words are never read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Advance pointers and keep occupancy in step with push/pop.
    // NOTE: sequential state is written with non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one fixed-latency FP16 adder among NREQ requesters,
// with ID tagging, credit-limited issue and a buffered valid/ready response port.
module fp_add_arbiter
    import fp_add_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int LAT   = 7,
    parameter int DEPTH = 9,
    parameter int ID_W  = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*FP16_W-1:0]   req_a,
    input  logic [NREQ*FP16_W-1:0]   req_b,
    output logic                     add_in_valid,
    output logic [FP16_W-1:0]        add_a,
    output logic [FP16_W-1:0]        add_b,
    input  logic [FP16_W-1:0]        add_res,
    input  logic [FLAG_W-1:0]        add_flags,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [FP16_W-1:0]        resp_sum,
    output logic [FLAG_W-1:0]        resp_flags,
    output logic                     busy
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant_id;
    logic              arb_found;
    logic              accept;
    logic              credit;
    logic [CNT_W:0]    committed;
    logic [FP16_W-1:0] sel_a;
    logic [FP16_W-1:0] sel_b;
    logic [ID_W-1:0]   issue_id;
    logic [LAT-1:0]    tag_valid;
    logic [ID_W-1:0]   tag_id [LAT];
    logic              capture;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  occ;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    rsp_entry_t        cap_entry;
    rsp_entry_t        head_entry;
    rsp_entry_t        hold_entry;
    rsp_entry_t        resp_entry;
    logic              unused_id_hi;

    // Requester index 'step' positions after 'from', wrapping NREQ-1 -> 0.
    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] from, input int step);
        int pos;
        pos = (int'(from) + step) % NREQ;
        return ID_W'(pos);
    endfunction

    // Credit: everything accepted but not yet popped must fit in the FIFO.
    assign committed = {1'b0, occ} + {1'b0, inflight};
    assign credit    = (committed < (CNT_W + 1)'(DEPTH));

    // Round-robin search starting one above the last grant; one-hot, only with credit.
    // NOTE: every output gets a default at the top of the block, so no path leaves a latch.
    always_comb begin
        req_ready = '0;
        grant_id  = '0;
        arb_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!arb_found && credit && req_valid[i] && (rr_next(last_grant, k) == ID_W'(i))) begin
                    arb_found    = 1'b1;
                    req_ready[i] = 1'b1;
                    grant_id     = ID_W'(i);
                end
            end
        end
    end

    assign accept = |(req_valid & req_ready);

    // Select the granted requester's operand lanes.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_a = req_a[i*FP16_W +: FP16_W];
                sel_b = req_b[i*FP16_W +: FP16_W];
            end
        end
    end

    // Remember the last granted requester; reset value makes requester 0 win first.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= ID_W'(NREQ - 1);
        end else if (accept) begin
            last_grant <= grant_id;
        end
    end

    // Issue register: one-cycle strobe to the adder, operands held between issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            add_in_valid <= 1'b0;
            add_a        <= '0;
            add_b        <= '0;
            issue_id     <= '0;
        end else begin
            add_in_valid <= accept;
            if (accept) begin
                add_a    <= sel_a;
                add_b    <= sel_b;
                issue_id <= grant_id;
            end
        end
    end

    // Tag pipe mirrors the adder latency; its last stage marks when add_res is meaningful.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid <= '0;
            for (int i = 0; i < LAT; i++) tag_id[i] <= '0;
        end else begin
            tag_valid[0] <= add_in_valid;
            tag_id[0]    <= issue_id;
            for (int i = 1; i < LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    assign capture = tag_valid[LAT-1];

    // Ops in the issue register or adder: +1 on accept, -1 on capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else if (accept && !capture) begin
            inflight <= inflight + 1'b1;
        end else if (!accept && capture) begin
            inflight <= inflight - 1'b1;
        end
    end

    // Build the FIFO entry from the returning tag and adder outputs.
    always_comb begin
        cap_entry            = '0;
        cap_entry.id         = RSP_ID_W'(tag_id[LAT-1]);
        cap_entry.sum        = add_res;
        cap_entry.flags[OVF] = add_flags[OVF];
        cap_entry.flags[UNF] = add_flags[UNF];
    end

    fp_add_rsp_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data (cap_entry),
        .pop       (pop),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occ)
    );

    assign resp_valid = ~fifo_empty;
    assign pop        = resp_valid & resp_ready;

    // Keep the last presented response so resp_* hold steady while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_entry <= '0;
        end else if (pop) begin
            hold_entry <= head_entry;
        end
    end

    assign resp_entry   = fifo_empty ? hold_entry : head_entry;
    assign resp_id      = resp_entry.id[ID_W-1:0];
    assign resp_sum     = resp_entry.sum;
    assign resp_flags   = resp_entry.flags;
    assign unused_id_hi = ^(resp_entry.id >> ID_W);

    assign busy = (inflight != '0) | (occ != '0);

    // Credit accounting must keep a capture from ever landing in a full FIFO.
    assert property (@(posedge clk) disable iff (reset) capture |-> !fifo_full);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter with a behavioural LAT-cycle FP16 adder model.
module tb_fp_add_arbiter;

    localparam int NREQ  = 2;
    localparam int LAT   = 7;
    localparam int DEPTH = 9;
    localparam int ID_W  = 1;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*16-1:0]   req_a;
    logic [NREQ*16-1:0]   req_b;
    logic                 add_in_valid;
    logic [15:0]          add_a;
    logic [15:0]          add_b;
    logic [15:0]          add_res;
    logic [1:0]           add_flags;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [ID_W-1:0]      resp_id;
    logic [15:0]          resp_sum;
    logic [1:0]           resp_flags;
    logic                 busy;

    fp_add_arbiter #(
        .NREQ  (NREQ),
        .LAT   (LAT),
        .DEPTH (DEPTH),
        .ID_W  (ID_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .add_in_valid (add_in_valid),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_res      (add_res),
        .add_flags    (add_flags),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_sum     (resp_sum),
        .resp_flags   (resp_flags),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FP16 add for positive normal operands (truncating); returns {flags,sum}, overflow -> +inf.
    function automatic logic [17:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic [4:0]  ea;
        logic [4:0]  eb;
        logic [5:0]  e;
        logic [11:0] ma;
        logic [11:0] mb;
        logic [11:0] ms;
        ea = a[14:10];
        eb = b[14:10];
        ma = {2'b01, a[9:0]};
        mb = {2'b01, b[9:0]};
        if (ea >= eb) begin
            e  = {1'b0, ea};
            mb = mb >> (ea - eb);
        end else begin
            e  = {1'b0, eb};
            ma = ma >> (eb - ea);
        end
        ms = ma + mb;
        if (ms[11]) begin
            ms = ms >> 1;
            e  = e + 6'd1;
        end
        if (e >= 6'd31) return {2'b10, 16'h7C00};
        return {2'b00, a[15], e[4:0], ms[9:0]};
    endfunction

    // Adder model: not reset; emits junk in cycles without a matching issue.
    logic [15:0] mdl_sum [LAT];
    logic [1:0]  mdl_flg [LAT];
    logic        mdl_v   [LAT];

    always @(posedge clk) begin
        mdl_v[0] <= add_in_valid;
        if (add_in_valid) begin
            {mdl_flg[0], mdl_sum[0]} <= fp16_add(add_a, add_b);
        end else begin
            mdl_sum[0] <= 16'hDEAD;
            mdl_flg[0] <= 2'b11;
        end
        for (int i = 1; i < LAT; i++) begin
            mdl_v[i]   <= mdl_v[i-1];
            mdl_sum[i] <= mdl_sum[i-1];
            mdl_flg[i] <= mdl_flg[i-1];
        end
    end

    assign add_res   = mdl_sum[LAT-1];
    assign add_flags = mdl_flg[LAT-1];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [15:0]     sum;
        logic [1:0]      flags;
    } rsp_t;

    rsp_t sb[$];
    int   n_accepts = 0;
    int   n_pops    = 0;
    int   coinc     = 0;

    // One clock: called just after a negedge with inputs set; observes accept/pop, ends at next negedge.
    task automatic cycle(output logic accepted, output int gid);
        logic [NREQ-1:0] acc;
        rsp_t            e;
        int              pre;
        logic            popping;
        #1;
        acc      = req_valid & req_ready;
        accepted = (acc != '0);
        gid      = 0;
        for (int k = 0; k < NREQ; k++) if (acc[k]) gid = k;
        pre     = sb.size();
        popping = resp_valid && resp_ready;
        if (popping) begin
            n_pops++;
            check("sb_nonempty_at_pop", 32'(pre != 0), 32'd1);
            if (pre != 0) begin
                e = sb.pop_front();
                check("resp_id", 32'(resp_id), 32'(e.id));
                check("resp_sum", 32'(resp_sum), 32'(e.sum));
                check("resp_flags", 32'(resp_flags), 32'(e.flags));
            end
        end
        if (accepted) begin
            n_accepts++;
            e.id = ID_W'(gid);
            {e.flags, e.sum} = fp16_add(req_a[gid*16 +: 16], req_b[gid*16 +: 16]);
            sb.push_back(e);
        end
        if (accepted && popping && mdl_v[LAT-1] && (pre == DEPTH - 1)) coinc++;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        logic a;
        int   g;
        int   n;
        n = 0;
        while ((busy || resp_valid) && n < 200) begin
            cycle(a, g);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [NREQ-1:0] valid;
        logic [15:0]     a;
        logic [15:0]     b;
        logic [NREQ-1:0] exp_ready;
        logic [ID_W-1:0] exp_id;
        logic [15:0]     exp_sum;
        logic [1:0]      exp_flags;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic a_acc;
        int   gid;
        int   lat;
        int   exp_gid;
        int   acc0;
        int   pop0;

        vecs[0] = '{2'b01, 16'h3C00, 16'h4000, 2'b01, 1'b0, 16'h4200, 2'b00};
        vecs[1] = '{2'b10, 16'h4000, 16'h4000, 2'b10, 1'b1, 16'h4400, 2'b00};
        vecs[2] = '{2'b01, 16'h7BFF, 16'h7BFF, 2'b01, 1'b0, 16'h7C00, 2'b10};
        vecs[3] = '{2'b10, 16'h3C00, 16'h3C00, 2'b10, 1'b1, 16'h4000, 2'b00};
        vecs[4] = '{2'b01, 16'h3800, 16'h3C00, 2'b01, 1'b0, 16'h3E00, 2'b00};
        vecs[5] = '{2'b11, 16'h4400, 16'h4400, 2'b10, 1'b1, 16'h4800, 2'b00};

        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_add_in_valid", 32'(add_in_valid), 32'd0);
        check("rst_add_a", 32'(add_a), 32'd0);
        check("rst_add_b", 32'(add_b), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_sum", 32'(resp_sum), 32'd0);
        check("rst_resp_flags", 32'(resp_flags), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single ops: grant, issue timing, latency, bit-exact return, RR pointer, overflow flags.
        for (int v = 0; v < 6; v++) begin
            req_valid = vecs[v].valid;
            req_a     = '0;
            req_b     = '0;
            for (int k = 0; k < NREQ; k++) begin
                if (vecs[v].valid[k]) begin
                    req_a[k*16 +: 16] = vecs[v].a;
                    req_b[k*16 +: 16] = vecs[v].b;
                end
            end
            #1;
            check($sformatf("v%0d_req_ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
            @(negedge clk);
            req_valid = '0;
            #1;
            check($sformatf("v%0d_add_in_valid", v), 32'(add_in_valid), 32'd1);
            check($sformatf("v%0d_add_a", v), 32'(add_a), 32'(vecs[v].a));
            check($sformatf("v%0d_add_b", v), 32'(add_b), 32'(vecs[v].b));
            lat = 1;
            while (!resp_valid && lat < 40) begin
                @(negedge clk);
                #1;
                lat++;
                if (lat == 2) check($sformatf("v%0d_issue_pulse", v), 32'(add_in_valid), 32'd0);
            end
            check($sformatf("v%0d_latency", v), 32'(lat), 32'(LAT + 2));
            check($sformatf("v%0d_resp_id", v), 32'(resp_id), 32'(vecs[v].exp_id));
            check($sformatf("v%0d_resp_sum", v), 32'(resp_sum), 32'(vecs[v].exp_sum));
            check($sformatf("v%0d_resp_flags", v), 32'(resp_flags), 32'(vecs[v].exp_flags));
            @(negedge clk);
            #1;
            check($sformatf("v%0d_drained", v), 32'({resp_valid, busy}), 32'd0);
            check($sformatf("v%0d_hold_sum", v), 32'(resp_sum), 32'(vecs[v].exp_sum));
            @(negedge clk);
        end

        // Contention: both requesters every cycle, grants alternate starting after the last grant.
        exp_gid       = (int'(vecs[5].exp_id) + 1) % NREQ;
        req_valid     = 2'b11;
        req_a[15:0]   = 16'h3C00;
        req_b[15:0]   = 16'h4000;
        req_a[31:16]  = 16'h4000;
        req_b[31:16]  = 16'h4000;
        for (int c = 0; c < 12; c++) begin
            cycle(a_acc, gid);
            if (a_acc) begin
                check("rr_grant", 32'(gid), 32'(exp_gid));
                exp_gid = (exp_gid + 1) % NREQ;
            end
        end
        req_valid = '0;
        wait_idle("contention_idle");
        check("contention_sb_empty", 32'(sb.size()), 32'd0);

        // Back-pressure: exactly DEPTH accepts with resp_ready low, then drain with no loss.
        acc0       = n_accepts;
        pop0       = n_pops;
        resp_ready = 1'b0;
        req_valid  = 2'b01;
        req_b      = {16'h0000, 16'h3C00};
        for (int c = 0; c < 30; c++) begin
            req_a[15:0] = 16'h3C00 + 16'(c);
            cycle(a_acc, gid);
        end
        #1;
        check("bp_accepts", 32'(n_accepts - acc0), 32'(DEPTH));
        check("bp_req_ready_low", 32'(req_ready), 32'd0);
        check("bp_resp_valid", 32'(resp_valid), 32'd1);
        resp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            req_a[15:0] = 16'h3D00 + 16'(c);
            cycle(a_acc, gid);
        end
        req_valid = '0;
        wait_idle("bp_idle");
        check("bp_sb_empty", 32'(sb.size()), 32'd0);
        check("bp_pops_eq_accepts", 32'(n_pops - pop0), 32'(n_accepts - acc0));

        // Streaming with resp_ready high: credit returns one cycle after pop, giving 9 of every 10 cycles.
        acc0      = n_accepts;
        coinc     = 0;
        req_valid = 2'b01;
        for (int c = 0; c < 30; c++) begin
            req_a[15:0] = 16'h4000 + 16'(c);
            cycle(a_acc, gid);
        end
        check("stream_accepts", 32'(n_accepts - acc0), 32'd27);
        check("coincident_seen", 32'(coinc != 0), 32'd1);
        req_valid = '0;
        wait_idle("stream_idle");
        check("stream_sb_empty", 32'(sb.size()), 32'd0);

        // Reset with three ops inside the adder: nothing stale may surface afterwards.
        req_valid = 2'b01;
        for (int c = 0; c < 3; c++) begin
            req_a[15:0] = 16'h4200 + 16'(c);
            cycle(a_acc, gid);
        end
        req_valid = '0;
        cycle(a_acc, gid);
        cycle(a_acc, gid);
        check("rm_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        cycle(a_acc, gid);
        reset = 1'b0;
        sb.delete();
        #1;
        check("rm_resp_valid", 32'(resp_valid), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_resp_sum", 32'(resp_sum), 32'd0);
        pop0 = n_pops;
        for (int c = 0; c < 20; c++) cycle(a_acc, gid);
        check("rm_stale_responses", 32'(n_pops - pop0), 32'd0);
        check("rm_busy_after", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
